// File: rtl/acc_pkg.sv
// Shared types and default constants for the accumulator feeder and the accumulator stage.
package acc_pkg;

  localparam int ACC_DATA_WIDTH  = 8;
  localparam int ACC_ATTR_WIDTH  = 4;
  localparam int ACC_HOLD_CYCLES = 2;
  localparam int ACC_FIFO_DEPTH  = 4;
  localparam int ACC_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic first;
    logic last;
    logic neg;
  } acc_flags_t;

  localparam int ACC_FLAGS_WIDTH = $bits(acc_flags_t);

  typedef struct packed {
    logic [ACC_DATA_WIDTH-1:0] data;
    logic [ACC_ATTR_WIDTH-1:0] attr;
    acc_flags_t                flags;
  } acc_entry_t;

endpackage

// File: rtl/acc_feeder_fifo.sv
// Synchronous operand FIFO; the head entry is read straight from the storage registers.
module acc_feeder_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_CT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == DEPTH_CT);
  assign o_empty   = (w_count == '0);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  // Full is judged before any same-cycle pop, so a full cycle never accepts.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/acc_feeder.sv
// Operand sequencer: buffers framed operands and drives the accumulator strobes,
// holding each operand for HOLD_CYCLES and closing each frame with one output cycle.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH  = ACC_DATA_WIDTH,
  parameter int ATTR_WIDTH  = ACC_ATTR_WIDTH,
  parameter int HOLD_CYCLES = ACC_HOLD_CYCLES,
  parameter int FIFO_DEPTH  = ACC_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ATTR_WIDTH-1:0] in_attr,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  in_neg,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  output logic                  done,
  output logic                  busy
);

  // Stream handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO occupancy, never on in_valid.

  localparam int EW = DATA_WIDTH + ATTR_WIDTH + ACC_FLAGS_WIDTH;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ACC_CNT_WIDTH-1:0] HOLD_LAST = ACC_CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [ACC_CNT_WIDTH-1:0] CNT_ONE   = ACC_CNT_WIDTH'(1);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [OW-1:0]         w_count;
  logic [OW-1:0]         w_occ_next;
  logic [EW-1:0]         w_wr_entry;
  logic [EW-1:0]         w_head;
  acc_flags_t            w_in_flags;
  acc_flags_t            w_head_flags;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ATTR_WIDTH-1:0] w_head_attr;

  acc_state_e             r_state;
  acc_state_e             w_state_next;
  logic [ACC_CNT_WIDTH-1:0] r_cnt;
  logic [ACC_CNT_WIDTH-1:0] w_cnt_next;
  logic                   r_last;

  logic                  r_load;
  logic                  r_init;
  logic                  r_neg;
  logic                  r_oe;
  logic                  r_done;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ATTR_WIDTH-1:0] r_attr;

  assign w_in_flags = '{first: in_first, last: in_last, neg: in_neg};
  assign w_wr_entry = {in_data, in_attr, w_in_flags};
  assign {w_head_data, w_head_attr, w_head_flags} = w_head;

  assign in_ready   = !w_full;
  assign w_push     = in_valid && !w_full;
  assign w_occ_next = w_count + OW'(w_push) - OW'(w_pop);

  acc_feeder_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = HOLD;
          w_cnt_next   = HOLD_LAST;
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else if (r_last) begin
          w_state_next = OUT;
        end else if (!w_empty) begin
          // Chain straight into the next operand with no idle gap.
          w_pop        = 1'b1;
          w_cnt_next   = HOLD_LAST;
        end else begin
          w_state_next = IDLE;
        end
      end
      OUT: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = HOLD;
          w_cnt_next   = HOLD_LAST;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_load  <= 1'b0;
      r_init  <= 1'b0;
      r_neg   <= 1'b0;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_attr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_load  <= (w_state_next == HOLD);
      r_init  <= w_pop && w_head_flags.first;
      r_oe    <= (w_state_next == OUT);
      r_done  <= (w_state_next == OUT);
      r_busy  <= (w_state_next != IDLE) || (w_occ_next != '0);
      if (w_pop) begin
        r_data <= w_head_data;
        r_attr <= w_head_attr;
        r_last <= w_head_flags.last;
        r_neg  <= w_head_flags.neg;
      end else if (w_state_next != HOLD) begin
        r_neg  <= 1'b0;
      end
    end
  end

  assign signal_load = r_load;
  assign signal_init = r_init;
  assign signal_neg  = r_neg;
  assign signal_oe   = r_oe;
  assign done        = r_done;
  assign busy        = r_busy;
  assign data_in     = r_data;
  assign attr_in     = r_attr;

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder with default parameters (HOLD_CYCLES=2, FIFO_DEPTH=4).
module tb_acc_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_attr;
  logic       in_first;
  logic       in_last;
  logic       in_neg;
  logic       signal_load;
  logic       signal_init;
  logic       signal_neg;
  logic       signal_oe;
  logic [7:0] data_in;
  logic [3:0] attr_in;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  acc_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_attr     (in_attr),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_neg      (in_neg),
    .signal_load (signal_load),
    .signal_init (signal_init),
    .signal_neg  (signal_neg),
    .signal_oe   (signal_oe),
    .data_in     (data_in),
    .attr_in     (attr_in),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic l, input logic n);
    in_valid = v;
    in_data  = d;
    in_attr  = d[3:0] ^ 4'h5;
    in_first = f;
    in_last  = l;
    in_neg   = n;
  endtask

  task automatic idle_in();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    logic acc;
    logic exp_rdy [10];
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_load", 32'(signal_load), 32'd0);
    chk("rst_init", 32'(signal_init), 32'd0);
    chk("rst_neg",  32'(signal_neg),  32'd0);
    chk("rst_oe",   32'(signal_oe),   32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_data", 32'(data_in),     32'd0);
    chk("rst_attr", 32'(attr_in),     32'd0);
    chk("rst_rdy",  32'(in_ready),    32'd1);

    // Basic frame 1(first),2,3,4(last)
    for (int c = 0; c <= 10; c++) begin
      if (c < 4) drive(1'b1, 8'(c + 1), c == 0, c == 3, 1'b0);
      else idle_in();
      tick();
      if (c == 0) begin
        chk("t1_lat_load", 32'(signal_load), 32'd0);
        chk("t1_lat_busy", 32'(busy), 32'd1);
      end
      if (c >= 1 && c <= 8) begin
        chk("t1_load", 32'(signal_load), 32'd1);
        chk("t1_data", 32'(data_in), 32'((c + 1) / 2));
        chk("t1_init", 32'(signal_init), 32'(c == 1));
        chk("t1_oe",   32'(signal_oe), 32'd0);
      end
      if (c == 1) chk("t1_attr", 32'(attr_in), 32'h4);
      if (c == 9) begin
        chk("t1_oe9",   32'(signal_oe), 32'd1);
        chk("t1_done9", 32'(done), 32'd1);
        chk("t1_load9", 32'(signal_load), 32'd0);
      end
      if (c == 10) begin
        chk("t1_oe10",   32'(signal_oe), 32'd0);
        chk("t1_busy10", 32'(busy), 32'd0);
        chk("t1_hold10", 32'(data_in), 32'd4);
      end
    end

    // Negation: 5(first), 3(neg,last)
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
      else if (c == 1) drive(1'b1, 8'd3, 1'b0, 1'b1, 1'b1);
      else idle_in();
      tick();
      if (c >= 1 && c <= 4) begin
        chk("t2_data", 32'(data_in), (c <= 2) ? 32'd5 : 32'd3);
        chk("t2_neg",  32'(signal_neg), 32'(c >= 3));
      end
      if (c == 3) chk("t2_attr", 32'(attr_in), 32'h6);
      if (c == 5) begin
        chk("t2_oe",  32'(signal_oe), 32'd1);
        chk("t2_neg5", 32'(signal_neg), 32'd0);
      end
    end
    tick();

    // Backpressure: 8 operands offered continuously into a 4-deep FIFO
    k = 0;
    for (int c = 0; c <= 18; c++) begin
      if (k < 8) drive(1'b1, 8'(k), k == 0, k == 7, 1'b0);
      else idle_in();
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      if (c <= 9) chk("t3_rdy", 32'(in_ready), 32'(exp_rdy[c]));
      if (c >= 1 && c <= 16) begin
        chk("t3_data", 32'(data_in), 32'((c - 1) / 2));
        chk("t3_load", 32'(signal_load), 32'd1);
      end
      if (c == 17) chk("t3_oe", 32'(signal_oe), 32'd1);
      if (c == 18) chk("t3_busy", 32'(busy), 32'd0);
    end
    chk("t3_accepted", 32'(k), 32'd8);

    // Single-operand frame: 7(first,last)
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) drive(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
      else idle_in();
      tick();
      if (c == 1) begin
        chk("t4_init", 32'(signal_init), 32'd1);
        chk("t4_data", 32'(data_in), 32'd7);
      end
      if (c == 2) begin
        chk("t4_load2", 32'(signal_load), 32'd1);
        chk("t4_init2", 32'(signal_init), 32'd0);
      end
      if (c == 3) begin
        chk("t4_oe",   32'(signal_oe), 32'd1);
        chk("t4_load3", 32'(signal_load), 32'd0);
      end
      if (c == 4) chk("t4_busy", 32'(busy), 32'd0);
    end

    // Reset while holding operand 2 of 4
    for (int c = 0; c <= 3; c++) begin
      drive(1'b1, 8'(c + 1), c == 0, c == 3, 1'b0);
      tick();
    end
    chk("t5_pre_data", 32'(data_in), 32'd2);
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_load", 32'(signal_load), 32'd0);
    chk("t5_init", 32'(signal_init), 32'd0);
    chk("t5_oe",   32'(signal_oe), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", 32'(data_in), 32'd0);
    chk("t5_rdy",  32'(in_ready), 32'd1);
    tick();
    chk("t5_empty_load", 32'(signal_load), 32'd0);
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) drive(1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
      else idle_in();
      tick();
      if (c == 1) begin
        chk("t5_new_data", 32'(data_in), 32'd9);
        chk("t5_new_init", 32'(signal_init), 32'd1);
      end
      if (c == 3) chk("t5_new_oe", 32'(signal_oe), 32'd1);
    end
    tick();

    // Gap in input: 1(first), idle, 2(last)
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) drive(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
      else if (c == 5) drive(1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
      else idle_in();
      tick();
      if (c >= 1 && c <= 7) chk("t6_oe", 32'(signal_oe), 32'd0);
      if (c == 1 || c == 2 || c == 6 || c == 7) chk("t6_load", 32'(signal_load), 32'd1);
      if (c >= 3 && c <= 5) begin
        chk("t6_gap_load", 32'(signal_load), 32'd0);
        chk("t6_gap_data", 32'(data_in), 32'd1);
      end
      if (c == 6) begin
        chk("t6_data2", 32'(data_in), 32'd2);
        chk("t6_init2", 32'(signal_init), 32'd0);
      end
      if (c == 8) chk("t6_oe8", 32'(signal_oe), 32'd1);
      if (c == 9) chk("t6_busy", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
